// File: rtl/coin_dispenser_if.sv
// coin_dispenser_if: load/restock/ack controls and coin handshake plus status
// between the change-return block and its controller.
interface coin_dispenser_if;
    logic       load;
    logic [3:0] amount;
    logic       restock;
    logic       ack;
    logic [1:0] coin;
    logic       valid;
    logic       busy;
    logic       done;
    logic [3:0] remaining;
    logic [3:0] pentLeft;
    logic [3:0] triLeft;
    modport master (
        output load, amount, restock, ack,
        input  coin, valid, busy, done, remaining, pentLeft, triLeft
    );
    modport slave (
        input  load, amount, restock, ack,
        output coin, valid, busy, done, remaining, pentLeft, triLeft
    );
endinterface

// File: rtl/coin_dispenser.sv
// coin_dispenser: pays back a credit as greedy pentagon/triangle/circle coins
// from finite pentagon and triangle stock under a valid/ack handshake.
module coin_dispenser #(
    parameter logic [3:0] PENT_STOCK = 4'd2,
    parameter logic [3:0] TRI_STOCK  = 4'd2
) (
    input logic            clock,
    input logic            reset,
    coin_dispenser_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DISPENSE, DONE} state_t;
    state_t     state, state_nxt;
    logic [3:0] rem, pent_cnt, tri_cnt, sel_val, rem_nxt;
    logic [1:0] sel;
    logic       take;
    always_comb begin
        sel     = (rem >= 4'd5 && pent_cnt != 4'd0) ? 2'b11 :
                  (rem >= 4'd3 && tri_cnt != 4'd0)  ? 2'b10 : 2'b01;
        sel_val = sel == 2'b11 ? 4'd5 : sel == 2'b10 ? 4'd3 : 4'd1;
        take    = state == DISPENSE && bus.ack;
        rem_nxt = rem > sel_val ? rem - sel_val : 4'd0;
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = !bus.load ? IDLE : bus.amount != 4'd0 ? DISPENSE : DONE;
            DISPENSE: state_nxt = take && rem_nxt == 4'd0 ? DONE : DISPENSE;
            default:  state_nxt = IDLE;
        endcase
    end
    // A restock together with a load lands first, so the first coin sees fresh stock.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            rem      <= 4'd0;
            pent_cnt <= PENT_STOCK;
            tri_cnt  <= TRI_STOCK;
        end else if (state == IDLE) begin
            if (bus.load) rem <= bus.amount;
            if (bus.restock) begin
                pent_cnt <= PENT_STOCK;
                tri_cnt  <= TRI_STOCK;
            end
        end else if (take) begin
            rem <= rem_nxt;
            if (sel == 2'b11) pent_cnt <= pent_cnt - 4'd1;
            if (sel == 2'b10) tri_cnt <= tri_cnt - 4'd1;
        end
    always_comb begin
        bus.valid     = state == DISPENSE;
        bus.coin      = state == DISPENSE ? sel : 2'b00;
        bus.busy      = state != IDLE;
        bus.done      = state == DONE;
        bus.remaining = rem;
        bus.pentLeft  = pent_cnt;
        bus.triLeft   = tri_cnt;
    end
endmodule
